// File: rtl/spu_fetch_pkg.sv
// Shared types and widths for the IF->ID fetch-bundle queue.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spu_fetch_pkg;

  localparam int PC_W_DEF    = 9;
  localparam int INSTR_W_DEF = 32;
  localparam int LANES_DEF   = 2;
  localparam int DEPTH_DEF   = 4;

  // Pointer indexes DEPTH entries; count must also represent DEPTH itself.
  localparam int PTR_W_DEF = $clog2(DEPTH_DEF);
  localparam int CNT_W_DEF = $clog2(DEPTH_DEF + 1);

  // Lane 0 is declared first so it lands in the most significant slice.
  typedef struct packed {
    logic [PC_W_DEF-1:0]                       pc;
    logic [0:LANES_DEF-1][INSTR_W_DEF-1:0]     instr;
    logic                                      find_nop;
  } fetch_bundle_t;

  // Flattened bundle width: {pc, instr lanes, find_nop}.
  function automatic int bundle_w(input int pc_w, input int instr_w, input int lanes);
    return pc_w + lanes * instr_w + 1;
  endfunction

endpackage

// File: rtl/if_fetch_queue_mem.sv
// Bundle storage: DEPTH x W register array, one write port, one async read port.
// Latency: write visible on the read port after the writing edge; read is combinational.
// Backpressure: none; the caller decides when to write.
module if_fetch_queue_mem
  import spu_fetch_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = bundle_w(PC_W_DEF, INSTR_W_DEF, LANES_DEF),
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  logic [W-1:0]     wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output logic [W-1:0]     rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  // Storage clears on reset so an empty queue presents all-zero head fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_fetch_queue.sv
// IF->ID fetch-bundle queue, DEPTH entries; IF_FETCH_QUEUE_BYPASS_EN adds empty-queue fall-through.
// Latency: 1 cycle in->out (0 cycles with bypass when empty).
// Backpressure: in_ready drops only when full; out_ready=0 holds the head; no pass-through when full.
module if_fetch_queue
  import spu_fetch_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter int LANES   = LANES_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [LANES*INSTR_W-1:0]   in_instr,
  input  logic                       in_nop,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [LANES*INSTR_W-1:0]   out_instr,
  output logic                       out_nop,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int BW    = bundle_w(PC_W, INSTR_W, LANES);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [BW-1:0]    wdata, rdata;
  logic             head_vld, full, enq, deq, byp_take;

  assign wdata    = {in_pc, in_instr, in_nop};
  assign head_vld = (count_q != '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign in_ready = !full;
  assign count    = count_q;

`ifdef IF_FETCH_QUEUE_BYPASS_EN
  // Empty queue: an incoming bundle is presented straight to ID; flush suppresses it.
  logic byp;
  assign byp       = !head_vld && in_valid;
  assign out_valid = (head_vld || in_valid) && !flush;
  assign {out_pc, out_instr, out_nop} = byp ? wdata : rdata;
  assign byp_take  = byp && out_ready && !flush;
`else
  assign out_valid = head_vld;
  assign {out_pc, out_instr, out_nop} = rdata;
  assign byp_take  = 1'b0;
`endif

  // A bundle consumed through the bypass path is never written into storage.
  assign enq = in_valid && in_ready && !flush && !byp_take;
  assign deq = head_vld && out_ready && !flush;

  if_fetch_queue_mem #(
    .DEPTH (DEPTH),
    .W     (BW),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (enq),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  // Next-state pointers/count; flush wins over any same-cycle enqueue or dequeue.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(enq);
      rd_ptr_d = rd_ptr_q + PTR_W'(deq);
      count_d  = count_q + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  // Control state registers; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: directed stimulus pushes expected bundles,
// a negedge monitor pops and compares every accepted head bundle.
// Honours IF_FETCH_QUEUE_BYPASS_EN for the fall-through scenario.
module tb_if_fetch_queue;
  import spu_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  in_pc;
  logic [63:0] in_instr;
  logic        in_nop;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  out_pc;
  logic [63:0] out_instr;
  logic        out_nop;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_bundle_t exp_q[$];

  if_fetch_queue dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_nop    (in_nop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_nop   (out_nop),
    .count     (count)
  );

  always #5 clk = ~clk;

  function automatic fetch_bundle_t mk(input logic [8:0] pc);
    fetch_bundle_t b;
    b.pc       = pc;
    b.instr[0] = 32'hA000_0000 | {23'd0, pc};
    b.instr[1] = 32'h5B00_0000 | {23'd0, pc};
    b.find_nop = pc[0];
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs shortly after the rising edge.
  task automatic drive(input logic v, input logic [8:0] pc, input logic rdy, input logic fl);
    fetch_bundle_t b;
    b = mk(pc);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_pc     = b.pc;
    in_instr  = b.instr;
    in_nop    = b.find_nop;
    out_ready = rdy;
    flush     = fl;
  endtask

  // Monitor: every head bundle ID will accept at the coming edge must match the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      fetch_bundle_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got pc 0x%0h, expected no bundle", out_pc);
      end else begin
        e = exp_q.pop_front();
        if ({out_pc, out_instr, out_nop} !== e) begin
          n_fail++;
          $display("FAIL head_bundle: got pc 0x%0h instr 0x%0h nop %0b, expected pc 0x%0h instr 0x%0h nop %0b",
                   out_pc, out_instr, out_nop, e.pc, e.instr, e.find_nop);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = '0;
    in_instr = '0; in_nop = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", 32'(out_pc), 32'd0);
    #10 rst_n = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // 1: asynchronous reset mid-traffic at count=3
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 9'(i), 1'b0, 1'b0);
      exp_q.push_back(mk(9'(i)));
    end
    drive(1'b0, 9'h0, 1'b0, 1'b0);
    chk("t1_count_pre", 32'(count), 32'd3);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t1_out_valid", 32'(out_valid), 32'd0);
    chk("t1_count", 32'(count), 32'd0);
    chk("t1_out_pc", 32'(out_pc), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    chk("t1_in_ready", 32'(in_ready), 32'd1);

    // 2: fill to DEPTH with ID stalled; fifth bundle dropped
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 9'h010 + 9'(i), 1'b0, 1'b0);
      exp_q.push_back(mk(9'h010 + 9'(i)));
    end
    drive(1'b1, 9'h014, 1'b0, 1'b0);
    chk("t2_count_full", 32'(count), 32'd4);
    chk("t2_in_ready", 32'(in_ready), 32'd0);
    drive(1'b0, 9'h0, 1'b0, 1'b0);
    chk("t2_count_hold", 32'(count), 32'd4);
    chk("t2_head_pc", 32'(out_pc), 32'h010);
    chk("t2_out_valid", 32'(out_valid), 32'd1);

    // 3: drain to 2, then 6 enq+deq pairs through pointer wrap
    drive(1'b0, 9'h0, 1'b1, 1'b0);
    drive(1'b0, 9'h0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 9'h020 + 9'(i), 1'b1, 1'b0);
      exp_q.push_back(mk(9'h020 + 9'(i)));
      chk("t3_count_steady", 32'(count), 32'd2);
    end
    drive(1'b0, 9'h0, 1'b0, 1'b0);
    chk("t3_count_end", 32'(count), 32'd2);

    // 4: full with simultaneous dequeue does not admit the enqueue
    drive(1'b1, 9'h030, 1'b0, 1'b0);
    exp_q.push_back(mk(9'h030));
    drive(1'b1, 9'h031, 1'b0, 1'b0);
    exp_q.push_back(mk(9'h031));
    drive(1'b1, 9'h032, 1'b1, 1'b0);
    chk("t4_count_full", 32'(count), 32'd4);
    chk("t4_in_ready_full", 32'(in_ready), 32'd0);
    drive(1'b0, 9'h0, 1'b0, 1'b0);
    chk("t4_count_after", 32'(count), 32'd3);
    chk("t4_in_ready", 32'(in_ready), 32'd1);
    chk("t4_head_pc", 32'(out_pc), 32'h025);

    // 5: flush beats same-cycle enqueue and dequeue
    drive(1'b1, 9'h0EE, 1'b1, 1'b1);
    exp_q.delete();
    drive(1'b0, 9'h0, 1'b0, 1'b0);
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    drive(1'b1, 9'h1A0, 1'b0, 1'b0);
    exp_q.push_back(mk(9'h1A0));
    drive(1'b0, 9'h0, 1'b0, 1'b0);
    chk("t5_head_valid", 32'(out_valid), 32'd1);
    chk("t5_head_pc", 32'(out_pc), 32'h1A0);
    chk("t5_count_one", 32'(count), 32'd1);
    drive(1'b0, 9'h0, 1'b1, 1'b0);
    drive(1'b0, 9'h0, 1'b0, 1'b0);
    chk("t5_count_drained", 32'(count), 32'd0);

    // 6: empty queue, bundle offered with ID ready
`ifdef IF_FETCH_QUEUE_BYPASS_EN
    drive(1'b1, 9'h055, 1'b1, 1'b0);
    exp_q.push_back(mk(9'h055));
    chk("t6_byp_valid", 32'(out_valid), 32'd1);
    chk("t6_byp_pc", 32'(out_pc), 32'h055);
    drive(1'b0, 9'h0, 1'b0, 1'b0);
    chk("t6_byp_count", 32'(count), 32'd0);
    chk("t6_byp_valid_after", 32'(out_valid), 32'd0);
`else
    drive(1'b1, 9'h055, 1'b1, 1'b0);
    chk("t6_nobyp_valid", 32'(out_valid), 32'd0);
    exp_q.push_back(mk(9'h055));
    drive(1'b0, 9'h0, 1'b1, 1'b0);
    chk("t6_nobyp_valid_next", 32'(out_valid), 32'd1);
    chk("t6_nobyp_pc", 32'(out_pc), 32'h055);
    drive(1'b0, 9'h0, 1'b0, 1'b0);
    chk("t6_nobyp_count", 32'(count), 32'd0);
`endif

    @(posedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
